alu_seq_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_seq_unit_if.sv | 27 ++
 rtl/alu_seq_divider.sv | 64 ++++++
 rtl/alu_seq_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding,
// result-source selects and the result-width helper.
package alu_pkg;

   localparam int ALU_WIDTH = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_DIV  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOTA = 4'd7,
      OP_NOTB = 4'd8,
      OP_REM  = 4'd9
   } op_e;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DIV  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Which register drives out_result while DONE
   localparam logic [1:0] SEL_RES = 2'd0;
   localparam logic [1:0] SEL_QUO = 2'd1;
   localparam logic [1:0] SEL_REM = 2'd2;

   function automatic int res_width(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/result handshake bundle for alu_seq_unit; the producer/consumer
// side uses the master modport, the unit uses slave.
interface alu_seq_unit_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic                            in_valid;
   logic                            in_ready;
   logic [3:0]                      in_op;
   logic [WIDTH-1:0]                in_a;
   logic [WIDTH-1:0]                in_b;
   logic                            out_valid;
   logic                            out_ready;
   logic [res_width(WIDTH)-1:0]     out_result;
   logic                            out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_err
   );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB-first, WIDTH iterations.
// Remainder port exists only when ALU_SEQ_REMAINDER_EN is defined.
module alu_seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
`ifdef ALU_SEQ_REMAINDER_EN
   output logic [WIDTH-1:0] remainder,
`endif
   output logic [WIDTH-1:0] quotient
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] dvs_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   diff_s;

   // quo_r starts as the dividend and shifts quotient bits in from the right
   assign shifted_s = {rem_r, quo_r[WIDTH-1]};
   assign diff_s    = shifted_s - {1'b0, dvs_r};

   // Load on start, then one trial subtraction per cycle while busy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo_r  <= '0;
         rem_r  <= '0;
         dvs_r  <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
      end else if (start) begin
         quo_r  <= dividend;
         rem_r  <= '0;
         dvs_r  <= divisor;
         cnt_r  <= '0;
         busy_r <= 1'b1;
      end else if (busy_r) begin
         quo_r  <= {quo_r[WIDTH-2:0], ~diff_s[WIDTH]};
         rem_r  <= diff_s[WIDTH] ? shifted_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
         cnt_r  <= cnt_r + CW'(1);
         if (cnt_r == LAST) begin
            busy_r <= 1'b0;
         end
      end
   end

   assign busy     = busy_r;
   assign done     = busy_r && (cnt_r == LAST);
   assign quotient = quo_r;
`ifdef ALU_SEQ_REMAINDER_EN
   assign remainder = rem_r;
`endif

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked multi-cycle ALU: single-cycle ADD/SUB/logic, iterative MUL/DIV.
// Define ALU_SEQ_REMAINDER_EN to enable opcode 9 (REM).
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_seq_unit_if.slave  bus
);
   localparam int RW = res_width(WIDTH);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_r;
   logic [RW-1:0]    res_r;
   logic             err_r;
   logic [1:0]       sel_r;
   logic [CW-1:0]    cnt_r;
   logic [RW-1:0]    mcand_r;
   logic [WIDTH-1:0] mplier_r;

   logic [RW-1:0]    a_ext_s;
   logic [RW-1:0]    b_ext_s;
   logic [RW-1:0]    mul_add_s;
   logic [RW-1:0]    dec_res_s;
   logic             dec_err_s;
   state_t           dec_state_s;
   logic [1:0]       dec_sel_s;
   logic             div_start_s;
   logic             div_busy_s;
   logic             div_done_s;
   logic [WIDTH-1:0] quo_s;
   logic [RW-1:0]    out_res_s;
`ifdef ALU_SEQ_REMAINDER_EN
   logic [WIDTH-1:0] rem_s;
`endif

   assign a_ext_s   = {{WIDTH{1'b0}}, bus.in_a};
   assign b_ext_s   = {{WIDTH{1'b0}}, bus.in_b};
   assign mul_add_s = mplier_r[0] ? mcand_r : '0;

   // Decode the offered request into its first state and immediate result
   always_comb begin
      dec_res_s   = '0;
      dec_err_s   = 1'b0;
      dec_state_s = ST_DONE;
      dec_sel_s   = SEL_RES;
      case (bus.in_op)
         OP_ADD:  dec_res_s = a_ext_s + b_ext_s;
         OP_SUB:  dec_res_s = a_ext_s - b_ext_s;
         OP_MUL:  dec_state_s = ST_MUL;
         OP_DIV: begin
            if (bus.in_b == '0) begin
               dec_res_s = '1;
               dec_err_s = 1'b1;
            end else begin
               dec_state_s = ST_DIV;
               dec_sel_s   = SEL_QUO;
            end
         end
`ifdef ALU_SEQ_REMAINDER_EN
         OP_REM: begin
            if (bus.in_b == '0) begin
               dec_res_s = '1;
               dec_err_s = 1'b1;
            end else begin
               dec_state_s = ST_DIV;
               dec_sel_s   = SEL_REM;
            end
         end
`endif
         OP_AND:  dec_res_s = a_ext_s & b_ext_s;
         OP_OR:   dec_res_s = a_ext_s | b_ext_s;
         OP_XOR:  dec_res_s = a_ext_s ^ b_ext_s;
         OP_NOTA: dec_res_s = {{WIDTH{1'b0}}, ~bus.in_a};
         OP_NOTB: dec_res_s = {{WIDTH{1'b0}}, ~bus.in_b};
         default: dec_err_s = 1'b1;
      endcase
   end

   assign div_start_s = (state_r == ST_IDLE) && bus.in_valid && (dec_state_s == ST_DIV);

   alu_seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start_s),
      .dividend  (bus.in_a),
      .divisor   (bus.in_b),
      .busy      (div_busy_s),
      .done      (div_done_s),
`ifdef ALU_SEQ_REMAINDER_EN
      .remainder (rem_s),
`endif
      .quotient  (quo_s)
   );

   // Control FSM plus inline shift-add multiplier accumulating into res_r
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         res_r    <= '0;
         err_r    <= 1'b0;
         sel_r    <= SEL_RES;
         cnt_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state_r  <= dec_state_s;
                  res_r    <= dec_res_s;
                  err_r    <= dec_err_s;
                  sel_r    <= dec_sel_s;
                  cnt_r    <= '0;
                  mcand_r  <= a_ext_s;
                  mplier_r <= bus.in_b;
               end
            end
            ST_MUL: begin
               res_r    <= res_r + mul_add_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + CW'(1);
               if (cnt_r == LAST) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DIV: begin
               if (div_done_s) begin
                  state_r <= ST_DONE;
               end else if (!div_busy_s) begin
                  state_r <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Result source is a registered select over registered values only
   always_comb begin
      out_res_s = res_r;
      case (sel_r)
         SEL_RES: out_res_s = res_r;
         SEL_QUO: out_res_s = {{WIDTH{1'b0}}, quo_s};
`ifdef ALU_SEQ_REMAINDER_EN
         SEL_REM: out_res_s = {{WIDTH{1'b0}}, rem_s};
`endif
         default: out_res_s = res_r;
      endcase
   end

   assign bus.in_ready   = rst_n && (state_r == ST_IDLE);
   assign bus.out_valid  = rst_n && (state_r == ST_DONE);
   assign bus.out_result = out_res_s;
   assign bus.out_err    = err_r;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq_unit;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   alu_seq_unit_if #(.WIDTH(W)) bus ();

   alu_seq_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour: result, error flag and accept-to-valid latency
   task automatic model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] res, output logic err, output int lat);
      int ai;
      int bi;
      ai  = int'(a);
      bi  = int'(b);
      res = 8'h00;
      err = 1'b0;
      lat = 1;
      case (op)
         4'd0: res = 8'(ai + bi);
         4'd1: res = 8'(ai - bi);
         4'd2: begin res = 8'(ai * bi); lat = 1 + W; end
         4'd3: begin
            if (bi == 0) begin res = 8'hFF; err = 1'b1; end
            else begin res = 8'(ai / bi); lat = 1 + W; end
         end
         4'd4: res = {4'h0, a & b};
         4'd5: res = {4'h0, a | b};
         4'd6: res = {4'h0, a ^ b};
         4'd7: res = {4'h0, ~a};
         4'd8: res = {4'h0, ~b};
`ifdef ALU_SEQ_REMAINDER_EN
         4'd9: begin
            if (bi == 0) begin res = 8'hFF; err = 1'b1; end
            else begin res = 8'(ai % bi); lat = 1 + W; end
         end
`endif
         default: begin res = 8'h00; err = 1'b1; end
      endcase
   endtask

   // Issue one request, check latency/result/err, hold backpressure bp cycles
   task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input int bp);
      logic [7:0] exp_res;
      logic       exp_err;
      int         exp_lat;
      int         lat;
      int         guard;
      logic       rdy_busy;
      model(op, a, b, exp_res, exp_err, exp_lat);
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_op    = 4'($urandom);
      bus.in_a     = 4'($urandom);
      bus.in_b     = 4'($urandom);
      lat      = 0;
      rdy_busy = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.in_ready) rdy_busy = 1'b1;
      end while (!bus.out_valid && lat < 20);
      check_eq($sformatf("lat op%0d", op), 32'(lat), 32'(exp_lat));
      check_eq($sformatf("res op%0d a%0d b%0d", op, a, b), 32'(bus.out_result), 32'(exp_res));
      check_eq($sformatf("err op%0d", op), 32'(bus.out_err), 32'(exp_err));
      check_eq("in_ready_busy", 32'(rdy_busy), 32'd0);
      repeat (bp) begin
         @(negedge clk);
         check_eq("bp_hold", {21'd0, bus.out_valid, bus.out_err, bus.out_result, bus.in_ready},
                  {21'd0, 1'b1, exp_err, exp_res, 1'b0});
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check_eq("post_xfer_rdy_vld", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_valid;
      logic [3:0] op;
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'd0;
      bus.in_a      = 4'd0;
      bus.in_b      = 4'd0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_result", 32'(bus.out_result), 32'd0);
      check_eq("rst_out_err", 32'(bus.out_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd1, 4'd0, 4'd15, 0);   // SUB -> 0xF1
      run_op(4'd0, 4'd15, 4'd15, 0);  // ADD -> 0x1E
      run_op(4'd2, 4'd15, 4'd15, 0);  // MUL -> 0xE1 at T+5
      run_op(4'd3, 4'd15, 4'd4, 0);   // DIV -> 0x03 at T+5
      run_op(4'd9, 4'd15, 4'd4, 0);   // REM or illegal depending on build
      run_op(4'd3, 4'd7, 4'd0, 0);    // DIV by zero -> 0xFF err
      run_op(4'd15, 4'd5, 4'd6, 0);   // illegal opcode
      run_op(4'd2, 4'd3, 4'd5, 5);    // backpressure on MUL result 0x0F

      // Reset in the middle of a DIV discards it
      while (bus.in_ready !== 1'b1) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = 4'd3;
      bus.in_a     = 4'd15;
      bus.in_b     = 4'd4;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid) saw_valid = 1'b1;
      end
      check_eq("rst_mid_div_no_valid", 32'(saw_valid), 32'd0);
      run_op(4'd0, 4'd1, 4'd2, 0);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 9));
         else op = 4'($urandom_range(0, 15));
         run_op(op, 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
